// File: rtl/vga_scan_out.sv
// vga_scan_out: VGA scan timing, pixel-index capture and fixed-palette RGB output.
module vga_scan_out #(
  parameter int CIDXW = 3,
  parameter int CORDW = 10,
  parameter int DIV = 4,
  parameter int H_TOTAL = 800,
  parameter int H_SYNC = 96,
  parameter int H_VIS_START = 144,
  parameter int H_VIS_END = 783,
  parameter int V_TOTAL = 525,
  parameter int V_SYNC = 2,
  parameter int V_VIS_START = 35,
  parameter int V_VIS_END = 514
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [CIDXW:0]   pix_in,
  output logic [CORDW-1:0] hc,
  output logic [CORDW-1:0] vc,
  output logic             pix_tick,
  output logic             line,
  output logic             frame,
  output logic             hSync,
  output logic             vSync,
  output logic             bright,
  output logic [11:0]      rgb
);
  localparam int DW = DIV > 1 ? $clog2(DIV) : 1;
  localparam logic [11:0] PAL [16] = '{
    12'h000, 12'hF00, 12'h0F0, 12'h00F, 12'hFF0, 12'h0FF, 12'hF0F, 12'hAAA,
    12'h555, 12'hF80, 12'h8F0, 12'h08F, 12'hF08, 12'h840, 12'hCCC, 12'hFFF
  };
  logic [DW-1:0] div;
  logic h_end, v_end, vis;
  logic [3:0] idx;
  always_comb begin
    pix_tick = div == DW'(DIV - 1);
    h_end = hc == CORDW'(H_TOTAL - 1);
    v_end = vc == CORDW'(V_TOTAL - 1);
    line = pix_tick && h_end;
    frame = line && v_end;
    vis = hc >= CORDW'(H_VIS_START) && hc <= CORDW'(H_VIS_END) &&
          vc >= CORDW'(V_VIS_START) && vc <= CORDW'(V_VIS_END);
    idx = 4'(pix_in);
  end
  // Sync/visibility/colour are taken from the pre-increment position, one pixel behind hc/vc.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      div <= '0;
      hc <= '0;
      vc <= '0;
      hSync <= 1'b1;
      vSync <= 1'b1;
      bright <= 1'b0;
      rgb <= '0;
    end else begin
      div <= pix_tick ? '0 : div + DW'(1);
      if (pix_tick) begin
        hc <= h_end ? '0 : hc + CORDW'(1);
        if (h_end) vc <= v_end ? '0 : vc + CORDW'(1);
        hSync <= hc >= CORDW'(H_SYNC);
        vSync <= vc >= CORDW'(V_SYNC);
        bright <= vis;
        rgb <= vis ? PAL[idx] : '0;
      end
    end
  end
endmodule

// File: tb/tb_vga_scan_out.sv
// tb_vga_scan_out: checks a reduced-geometry vga_scan_out against a position/tick model.
module tb_vga_scan_out;
  localparam int D = 4, HT = 100, HS = 12, HVS = 18, HVE = 97;
  localparam int VT = 20, VS = 2, VVS = 5, VVE = 18;
  localparam logic [11:0] PAL [16] = '{
    12'h000, 12'hF00, 12'h0F0, 12'h00F, 12'hFF0, 12'h0FF, 12'hF0F, 12'hAAA,
    12'h555, 12'hF80, 12'h8F0, 12'h08F, 12'hF08, 12'h840, 12'hCCC, 12'hFFF
  };
  logic clk = 1'b0, rst_n = 1'b0;
  logic [3:0] pix_in = '0;
  logic [9:0] hc, vc;
  logic pix_tick, line, frame, hSync, vSync, bright;
  logic [11:0] rgb;
  int errs = 0, checks = 0;
  int n, t, cyc = 0, hs_run, vs_run, last_line, last_frame, frames, hmax = 0, vmax = 0;
  logic e_hs, e_vs, e_br;
  logic [11:0] e_rgb;

  vga_scan_out #(
    .CIDXW(3), .CORDW(10), .DIV(D),
    .H_TOTAL(HT), .H_SYNC(HS), .H_VIS_START(HVS), .H_VIS_END(HVE),
    .V_TOTAL(VT), .V_SYNC(VS), .V_VIS_START(VVS), .V_VIS_END(VVE)
  ) dut (
    .Clk(clk), .Reset(rst_n), .pix_in(pix_in), .hc(hc), .vc(vc),
    .pix_tick(pix_tick), .line(line), .frame(frame),
    .hSync(hSync), .vSync(vSync), .bright(bright), .rgb(rgb)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Directed colour indices at the window edges, forced 15 in vertical blanking, random elsewhere.
  function automatic logic [3:0] pick(input int h, input int v);
    if (v < VVS) return 4'd15;
    if (h == HVS && v == VVS) return 4'd7;
    if (h == HVE || h == HVE + 1) return 4'd15;
    return 4'($urandom_range(0, 15));
  endfunction

  task automatic restart();
    n = 0; t = 0; hs_run = 0; vs_run = 0; last_line = -1; last_frame = -1; frames = 0;
    e_hs = 1'b1; e_vs = 1'b1; e_br = 1'b0; e_rgb = '0;
    pix_in = pick(0, 0);
  endtask

  task automatic step();
    bit tk;
    int hm, vm;
    tk = (n % D) == D - 1;
    hm = t % HT;
    vm = (t / HT) % VT;
    chk("pix_tick", pix_tick, tk);
    chk("hc", hc, hm);
    chk("vc", vc, vm);
    chk("line", line, tk && hm == HT - 1);
    chk("frame", frame, tk && hm == HT - 1 && vm == VT - 1);
    chk("hSync", hSync, e_hs);
    chk("vSync", vSync, e_vs);
    chk("bright", bright, e_br);
    chk("rgb", rgb, e_rgb);
    if (line) begin
      if (last_line >= 0) chk("line_period", cyc - last_line, HT * D);
      last_line = cyc;
    end
    if (frame) begin
      frames++;
      chk("frame_on_line", line, 1);
      if (last_frame >= 0) chk("frame_period", cyc - last_frame, HT * VT * D);
      last_frame = cyc;
    end
    if (int'(hc) > hmax) hmax = hc;
    if (int'(vc) > vmax) vmax = vc;
    if (tk) begin
      if (!hSync) hs_run++;
      else if (hs_run > 0) begin chk("hsync_len", hs_run, HS); hs_run = 0; end
      if (!vSync) vs_run++;
      else if (vs_run > 0) begin chk("vsync_len", vs_run, VS * HT); vs_run = 0; end
      e_hs = hm >= HS;
      e_vs = vm >= VS;
      e_br = hm >= HVS && hm <= HVE && vm >= VVS && vm <= VVE;
      e_rgb = e_br ? PAL[pix_in] : 12'h000;
      t++;
    end else if (n % D == 0) pix_in = pick(t % HT, (t / HT) % VT);
    @(negedge clk);
    n++;
    cyc++;
  endtask

  initial begin
    repeat (5) @(negedge clk);
    chk("rst_hc", hc, 0);
    chk("rst_vc", vc, 0);
    chk("rst_tick", pix_tick, 0);
    chk("rst_line", line, 0);
    chk("rst_frame", frame, 0);
    chk("rst_hsync", hSync, 1);
    chk("rst_vsync", vSync, 1);
    chk("rst_bright", bright, 0);
    chk("rst_rgb", rgb, 0);
    rst_n = 1'b1;
    restart();
    while (!(t == HT * VT + 10 * HT + 50 && n % D == 0)) step();
    chk("frames_before_reset", frames, 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_hc", hc, 0);
    chk("mid_vc", vc, 0);
    chk("mid_tick", pix_tick, 0);
    chk("mid_hsync", hSync, 1);
    chk("mid_vsync", vSync, 1);
    chk("mid_bright", bright, 0);
    chk("mid_rgb", rgb, 0);
    rst_n = 1'b1;
    restart();
    repeat (2 * HT * VT * D + 8) step();
    chk("frames_after_reset", frames, 2);
    chk("hc_max", hmax, HT - 1);
    chk("vc_max", vmax, VT - 1);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/vga_scan_out.md
# vga_scan_out

Display-side end of the pixel-index interface. Generates the 640x480@60 scan position (`hc`, `vc`) and the `line` strobe that the background, sprite and level generators consume. Registers the 4-bit colour index they return and maps it through a fixed palette to 12-bit RGB. Drives the VGA connector: syncs, RGB, `bright`.

## Interface
- `CIDXW`, default 3: colour index is `CIDXW+1` bits wide.
- `CORDW`, default 10: width of `hc` and `vc`.
- `DIV`, default 4: `Clk` cycles per pixel; 100 MHz in gives a 25 MHz pixel rate.
- `H_TOTAL` 800, `H_SYNC` 96, `H_VIS_START` 144, `H_VIS_END` 783.
- `V_TOTAL` 525, `V_SYNC` 2, `V_VIS_START` 35, `V_VIS_END` 514.

Ports (name, direction, width, meaning):
- `Clk` in 1: single system clock; all logic runs on its rising edge.
- `Reset` in 1: synchronous, active-low; when low at a rising `Clk` edge, all state is reset.
- `pix_in` in `CIDXW+1`: colour index from the pixel generators for the current (`hc`, `vc`).
- `hc` out `CORDW`: horizontal count, 0..`H_TOTAL`-1.
- `vc` out `CORDW`: vertical count, 0..`V_TOTAL`-1.
- `pix_tick` out 1: one-`Clk` strobe; counters advance and `pix_in` is sampled on it.
- `line` out 1: one-`Clk` strobe on the tick where `hc` wraps to 0.
- `frame` out 1: one-`Clk` strobe on the tick where both `hc` and `vc` wrap to 0.
- `hSync` out 1: active-low horizontal sync.
- `vSync` out 1: active-low vertical sync.
- `bright` out 1: high inside the visible window.
- `rgb` out 12: {R[3:0], G[3:0], B[3:0]}; 0 when not `bright`.

## Operation
- **Divider:** `div` counts 0..`DIV`-1 and wraps.
  - `pix_tick` = 1 in the cycle where `div` == `DIV`-1.
- **Counters** update only on `pix_tick`:
  - `hc` increments; at `H_TOTAL`-1 it wraps to 0 and `vc` increments.
  - `vc` wraps from `V_TOTAL`-1 to 0.
  - Simultaneous wrap of both counters asserts both `line` and `frame`.
- **Output stage:** registered on `pix_tick`, computed from the pre-increment (`hc`, `vc`):
  - `hSync` = 0 when `hc` < `H_SYNC`.
  - `vSync` = 0 when `vc` < `V_SYNC`.
  - `bright` = 1 when `hc` is in [`H_VIS_START`, `H_VIS_END`] and `vc` is in [`V_VIS_START`, `V_VIS_END`].
  - `rgb` = palette(`pix_in`) when `bright`, else 0x000.
- **Palette**, fixed ROM:
  - 0: 000, 1: F00, 2: 0F0, 3: 00F, 4: FF0, 5: 0FF, 6: F0F, 7: AAA
  - 8: 555, 9: F80, 10: 8F0, 11: 08F, 12: F08, 13: 840, 14: CCC, 15: FFF
- **Index width:** when `CIDXW` < 3, the upper index bits are zero-extended.
- `pix_in` is a don't-care outside the visible window; it must not affect `rgb`.

## Timing
- **Reset values:** `div`=0, `hc`=0, `vc`=0, `pix_tick`=0, `line`=0, `frame`=0, `hSync`=1, `vSync`=1, `bright`=0, `rgb`=0.
- **First tick:** the first `pix_tick` occurs on the `DIV`th rising edge after `Reset` deasserts; after that, one tick every `DIV` cycles.
- **Counter hold:** `hc` and `vc` are stable for `DIV` cycles. `pix_in` must settle within `DIV`-1 cycles of a change; the pixel generators register it one `Clk` later.
- **Output latency:** `hSync`, `vSync`, `bright` and `rgb` lag `hc`/`vc` by one pixel period (`DIV` cycles), so all four stay mutually aligned.
- **Strobes:** `line` and `frame` are high for exactly one `Clk`, coincident with `pix_tick`.
- **Periods:** line = 800 ticks = 3200 `Clk`; frame = 525 lines = 420000 ticks.
- **Reset mid-frame:** all outputs return to their reset values on the next edge. No partial sync pulse is extended.

## Test plan
- **Reset:** hold `Reset`=0 for 5 cycles, release -> all outputs at reset values; first `pix_tick` on cycle 4 after release; then a tick every 4 cycles, with 3 low cycles between.
- **Horizontal timing:** run 2 lines -> `hSync` low for exactly 96 ticks starting at `hc`=0 (visible 1 tick later); `line` strobes 3200 `Clk` apart; `hc` max 799.
- **Vertical timing:** run 1 full frame -> `vSync` low for exactly 1600 ticks (2 lines); `frame` once per 420000 ticks, coincident with a `line` strobe; `vc` max 524.
- **Visible pixel:** `pix_in`=7 held with counters at `hc`=144, `vc`=35 -> next tick `bright`=1 and `rgb`=AAA. With `pix_in`=15 at `hc`=783 -> `rgb`=FFF; at `hc`=784 -> `bright`=0, `rgb`=000.
- **Blanking:** `pix_in`=15 throughout `vc`=0..34 -> `rgb` stays 000 and `bright` stays 0 for the whole interval.
- **Reset mid-frame:** assert `Reset`=0 at `hc`=50, `vc`=200 for 1 cycle -> next edge `hc`=0, `vc`=0, `hSync`=1, `rgb`=0; normal timing resumes with a full 96-tick `hSync` pulse.
